// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one main-memory block port between an instruction cache (read only)
//   and a data cache (read/write). One transaction runs at a time; when both
//   sides ask together, the side that was not served last wins.
//
//   Ports
//     CLK, RESET                 clock, asynchronous active-low reset
//     I_READ, I_ADDRESS          instruction-side block read request
//     I_READDATA, I_BUSYWAIT     instruction block returned (registered), stall
//     D_READ, D_WRITE            data-side block read / write request
//     D_ADDRESS, D_WRITEDATA     data-side address and block to write
//     D_READDATA, D_BUSYWAIT     data block returned (registered), stall
//     MEM_READ, MEM_WRITE        registered main-memory strobes
//     MEM_ADDRESS, MEM_WRITEDATA address / block latched at grant time
//     MEM_READDATA, MEM_BUSYWAIT main-memory return block and busy flag
module memory_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   I_READ,
    input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] I_READDATA,
    output logic                   I_BUSYWAIT,
    input  logic                   D_READ,
    input  logic                   D_WRITE,
    input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
    output logic [BLOCK_WIDTH-1:0] D_READDATA,
    output logic                   D_BUSYWAIT,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
    input  logic                   MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,   // strobes just went out; memory has not reacted yet
        BUSY,    // waiting for MEM_BUSYWAIT to fall
        DONE     // one-cycle release of the granted requester
    } state_t;

    state_t state, state_next;
    logic   grant;        // 0 = instruction side, 1 = data side
    logic   last;         // side served by the most recent completed transaction
    logic   i_req;
    logic   d_req;
    logic   any_req;
    logic   grant_pick;   // side that would win if granted this cycle

    assign i_req   = I_READ;
    assign d_req   = D_READ | D_WRITE;
    assign any_req = i_req | d_req;

    // A lone request wins outright; a tie goes to the side not served last.
    assign grant_pick = (i_req && d_req) ? ~last : d_req;

    // Releasing a requester only during DONE of its own grant keeps the other
    // side stalled for the whole transaction.
    assign I_BUSYWAIT = i_req & ~((state == DONE) & ~grant);
    assign D_BUSYWAIT = d_req & ~((state == DONE) &  grant);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples
            // the pre-edge values and simulation matches the synthesized netlist.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: next-state gets a default before the case so no path through
        // this block leaves it unassigned, which would infer a latch.
        state_next = state;
        unique case (state)
            IDLE:  if (any_req) state_next = ISSUE;
            ISSUE: state_next = BUSY;
            BUSY:  if (!MEM_BUSYWAIT) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant, strobes, latched request and returned data. The wide data
    // registers are reset as well because their reset value is visible to
    // both requesters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            grant         <= 1'b0;
            last          <= 1'b1;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= grant_pick;
                        if (grant_pick) begin
                            // Read and write together counts as a write.
                            MEM_ADDRESS   <= D_ADDRESS;
                            MEM_WRITEDATA <= D_WRITEDATA;
                            MEM_WRITE     <= D_WRITE;
                            MEM_READ      <= ~D_WRITE;
                        end else begin
                            MEM_ADDRESS   <= I_ADDRESS;
                            MEM_WRITE     <= 1'b0;
                            MEM_READ      <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!MEM_BUSYWAIT) begin
                        // Data is captured even if the requester has since
                        // dropped its request.
                        if (MEM_READ) begin
                            if (grant) D_READDATA <= MEM_READDATA;
                            else       I_READDATA <= MEM_READDATA;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        last      <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Directed bench for memory_arbiter. A behavioural memory answers the
//   strobes with a programmable busy time; a transaction-level model predicts
//   every output and is compared on each falling edge. Directed scenarios add
//   hand-computed literal expectations.
module tb_memory_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_READ;
    logic [AW-1:0] I_ADDRESS;
    logic [BW-1:0] I_READDATA;
    logic          I_BUSYWAIT;
    logic          D_READ;
    logic          D_WRITE;
    logic [AW-1:0] D_ADDRESS;
    logic [BW-1:0] D_WRITEDATA;
    logic [BW-1:0] D_READDATA;
    logic          D_BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [AW-1:0] MEM_ADDRESS;
    logic [BW-1:0] MEM_WRITEDATA;
    logic [BW-1:0] MEM_READDATA = '0;
    logic          MEM_BUSYWAIT = 1'b0;

    memory_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .I_READ       (I_READ),
        .I_ADDRESS    (I_ADDRESS),
        .I_READDATA   (I_READDATA),
        .I_BUSYWAIT   (I_BUSYWAIT),
        .D_READ       (D_READ),
        .D_WRITE      (D_WRITE),
        .D_ADDRESS    (D_ADDRESS),
        .D_WRITEDATA  (D_WRITEDATA),
        .D_READDATA   (D_READDATA),
        .D_BUSYWAIT   (D_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Block the memory returns for a read of address a.
    function automatic logic [BW-1:0] pattern(input logic [AW-1:0] a);
        return {4{4'hC, a}};
    endfunction

    // ---------------- behavioural main memory ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } mem_txn_t;

    mem_txn_t      log_q[$];
    int            mem_lat  = 1;
    bit            ovr_en   = 1'b0;
    logic [BW-1:0] ovr_data = '0;
    bit            mem_active = 1'b0;
    int            mem_rem    = 0;

    always @(negedge CLK) begin
        if (!(MEM_READ || MEM_WRITE)) begin
            mem_active   = 1'b0;
            MEM_BUSYWAIT = 1'b0;
        end else if (!mem_active) begin
            mem_active   = 1'b1;
            MEM_BUSYWAIT = 1'b1;
            mem_rem      = mem_lat;
            log_q.push_back('{MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA});
        end else if (MEM_BUSYWAIT) begin
            mem_rem--;
            if (mem_rem == 0) begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = ovr_en ? ovr_data : pattern(MEM_ADDRESS);
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    // One transaction at a time: granted, memory polled from the second edge
    // on, then a single release cycle and a single idle edge before the next.
    bit            m_inflight = 1'b0;
    bit            m_seen     = 1'b0;
    bit            m_done     = 1'b0;
    bit            m_side     = 1'b0;
    bit            m_last     = 1'b1;
    bit            m_rd       = 1'b0;
    bit            m_wr       = 1'b0;
    logic [AW-1:0] m_addr     = '0;
    logic [BW-1:0] m_wdata    = '0;
    logic [BW-1:0] m_ird      = '0;
    logic [BW-1:0] m_drd      = '0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_inflight <= 1'b0;
            m_seen     <= 1'b0;
            m_done     <= 1'b0;
            m_side     <= 1'b0;
            m_last     <= 1'b1;
            m_rd       <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_ird      <= '0;
            m_drd      <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_inflight) begin
            if (m_seen && !MEM_BUSYWAIT) begin
                if (m_rd) begin
                    if (m_side) m_drd <= MEM_READDATA;
                    else        m_ird <= MEM_READDATA;
                end
                m_rd       <= 1'b0;
                m_wr       <= 1'b0;
                m_last     <= m_side;
                m_inflight <= 1'b0;
                m_done     <= 1'b1;
            end
            m_seen <= 1'b1;
        end else if (I_READ || D_READ || D_WRITE) begin
            m_inflight <= 1'b1;
            m_seen     <= 1'b0;
            if (I_READ && (D_READ || D_WRITE) ? !m_last : !I_READ) begin
                m_side  <= 1'b1;
                m_addr  <= D_ADDRESS;
                m_wdata <= D_WRITEDATA;
                m_wr    <= D_WRITE;
                m_rd    <= !D_WRITE;
            end else begin
                m_side <= 1'b0;
                m_addr <= I_ADDRESS;
                m_wr   <= 1'b0;
                m_rd   <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        check("mem_read",      128'(MEM_READ),      128'(m_rd));
        check("mem_write",     128'(MEM_WRITE),     128'(m_wr));
        check("mem_address",   128'(MEM_ADDRESS),   128'(m_addr));
        check("mem_writedata", MEM_WRITEDATA,       m_wdata);
        check("i_readdata",    I_READDATA,          m_ird);
        check("d_readdata",    D_READDATA,          m_drd);
        check("i_busywait",    128'(I_BUSYWAIT),    128'(I_READ && !(m_done && !m_side)));
        check("d_busywait",    128'(D_BUSYWAIT),    128'((D_READ || D_WRITE) && !(m_done && m_side)));
        check("rd_wr_exclusive", 128'(MEM_READ & MEM_WRITE), 128'(0));
    end

    // ---------------- stimulus helpers ----------------
    int cnt_mem_rd;
    int cnt_i_low;
    int cnt_d_high;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Hold the current requests until each side sees its busywait drop, then
    // withdraw that side, as a cache would.
    task automatic serve(input int bound);
        bit drop_i;
        bit drop_d;
        cnt_mem_rd = 0;
        cnt_i_low  = 0;
        cnt_d_high = 0;
        for (int n = 0; n < bound; n++) begin
            @(negedge CLK);
            if (!I_READ && !D_READ && !D_WRITE) break;
            if (MEM_READ) cnt_mem_rd++;
            drop_i = I_READ && !I_BUSYWAIT;
            drop_d = (D_READ || D_WRITE) && !D_BUSYWAIT;
            if (drop_i) cnt_i_low++;
            if ((D_READ || D_WRITE) && D_BUSYWAIT) cnt_d_high++;
            step();
            if (drop_i) I_READ = 1'b0;
            if (drop_d) begin
                D_READ  = 1'b0;
                D_WRITE = 1'b0;
            end
        end
        check("serve_completes", 128'(I_READ | D_READ | D_WRITE), 128'(0));
    endtask

    task automatic wait_strobe(input int bound);
        bit seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(negedge CLK);
            seen = MEM_READ || MEM_WRITE;
        end
        check("strobe_seen", 128'(seen), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int base;

    initial begin
        RESET       = 1'b0;
        I_READ      = 1'b0;
        I_ADDRESS   = '0;
        D_READ      = 1'b0;
        D_WRITE     = 1'b0;
        D_ADDRESS   = '0;
        D_WRITEDATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_mem_read",   128'(MEM_READ),    128'(0));
        check("reset_i_readdata", I_READDATA,        128'(0));
        step();
        RESET = 1'b1;

        // Instruction read, memory busy three cycles.
        mem_lat   = 3;
        ovr_en    = 1'b1;
        ovr_data  = {16{8'hA5}};
        base      = log_q.size();
        I_ADDRESS = 28'h0000010;
        I_READ    = 1'b1;
        serve(40);
        check("t1_mem_read_cycles", 128'(cnt_mem_rd), 128'(4));
        check("t1_i_busywait_low",  128'(cnt_i_low),  128'(1));
        check("t1_i_readdata",      I_READDATA,       {16{8'hA5}});
        check("t1_txn_count",       128'(log_q.size()), 128'(base + 1));
        ovr_en  = 1'b0;
        mem_lat = 1;

        // Simultaneous inst read and data write straight after reset.
        RESET = 1'b0;
        step();
        RESET       = 1'b1;
        base        = log_q.size();
        I_ADDRESS   = 28'h0000040;
        I_READ      = 1'b1;
        D_ADDRESS   = 28'h0000050;
        D_WRITEDATA = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        D_WRITE     = 1'b1;
        serve(60);
        check("t2_txn_count", 128'(log_q.size()), 128'(base + 2));
        if (log_q.size() >= base + 2) begin
            check("t2_first_addr",   128'(log_q[base].addr),     128'(28'h0000040));
            check("t2_first_wr",     128'(log_q[base].wr),       128'(0));
            check("t2_second_addr",  128'(log_q[base+1].addr),   128'(28'h0000050));
            check("t2_second_wr",    128'(log_q[base+1].wr),     128'(1));
            check("t2_second_wdata", log_q[base+1].wdata, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
        end
        check("t2_d_busy_cycles", 128'(cnt_d_high), 128'(7));
        check("t2_i_readdata",    I_READDATA,       pattern(28'h0000040));

        // Both sides requesting continuously: grants alternate I,D,I,D.
        base      = log_q.size();
        I_ADDRESS = 28'h0000100;
        D_ADDRESS = 28'h0000200;
        I_READ    = 1'b1;
        D_READ    = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (log_q.size() >= base + 4) break;
            step();
        end
        step();
        I_READ = 1'b0;
        D_READ = 1'b0;
        repeat (6) step();
        check("t3_txn_count", 128'(log_q.size()), 128'(base + 4));
        for (int i = 0; i < 4 && base + i < log_q.size(); i++)
            check("t3_grant_order", 128'(log_q[base+i].addr),
                  128'((i % 2 == 1) ? 28'h0000200 : 28'h0000100));
        check("t3_d_readdata_after_drop", D_READDATA, pattern(28'h0000200));

        // Address changed by the requester while its read is in BUSY.
        mem_lat   = 2;
        D_ADDRESS = 28'h0000020;
        D_READ    = 1'b1;
        wait_strobe(10);
        step();
        D_ADDRESS = 28'h0000030;
        @(negedge CLK);
        check("t4_mem_address_busy", 128'(MEM_ADDRESS), 128'(28'h0000020));
        serve(30);
        check("t4_mem_address_after", 128'(MEM_ADDRESS), 128'(28'h0000020));
        check("t4_d_readdata",        D_READDATA,         pattern(28'h0000020));

        // Reset pulsed during BUSY of a data read.
        mem_lat   = 4;
        D_ADDRESS = 28'h0000060;
        D_READ    = 1'b1;
        wait_strobe(10);
        step();
        step();
        #2;
        RESET = 1'b0;
        #1;
        check("t5_mem_read_reset",   128'(MEM_READ),    128'(0));
        check("t5_d_readdata_reset", D_READDATA,        128'(0));
        check("t5_mem_address_reset", 128'(MEM_ADDRESS), 128'(0));
        D_READ = 1'b0;
        step();
        RESET = 1'b1;
        repeat (3) step();
        check("t5_d_readdata_held", D_READDATA, 128'(0));
        mem_lat   = 1;
        base      = log_q.size();
        I_ADDRESS = 28'h0000300;
        D_ADDRESS = 28'h0000400;
        I_READ    = 1'b1;
        D_READ    = 1'b1;
        serve(60);
        check("t5_txn_count", 128'(log_q.size()), 128'(base + 2));
        if (log_q.size() >= base + 1)
            check("t5_first_after_reset", 128'(log_q[base].addr), 128'(28'h0000300));
        check("t5_d_readdata", D_READDATA, pattern(28'h0000400));

        // Read and write together behave as a write.
        D_ADDRESS   = 28'h0000070;
        D_WRITEDATA = 128'hfeed_face_cafe_beef_0123_4567_89ab_cdef;
        D_READ      = 1'b1;
        D_WRITE     = 1'b1;
        wait_strobe(10);
        check("t6_mem_write", 128'(MEM_WRITE), 128'(1));
        check("t6_mem_read",  128'(MEM_READ),  128'(0));
        serve(30);
        check("t6_d_readdata_unchanged", D_READDATA, pattern(28'h0000400));
        if (log_q.size() > 0)
            check("t6_wdata", log_q[log_q.size()-1].wdata,
                  128'hfeed_face_cafe_beef_0123_4567_89ab_cdef);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
